// File: rtl/pipeline_control_unit_if.sv
// Control/hazard bundle between the decoders, datapath and pipeline_control_unit.
interface pipeline_control_unit_if #(
  parameter int ADDR_W = 5
);
  logic              RegWriteD;
  logic [1:0]        ResultSrcD;
  logic              MemWriteD;
  logic              JumpD;
  logic              BranchD;
  logic              ALUSrcD;
  logic [1:0]        ALUOpD;
  logic [ADDR_W-1:0] Rs1D;
  logic [ADDR_W-1:0] Rs2D;
  logic [ADDR_W-1:0] RdD;
  logic              BrCondE;
  logic              dmem_ready;

  logic              ALUSrcE;
  logic [1:0]        ALUOpE;
  logic              MemWriteM;
  logic [1:0]        ResultSrcW;
  logic              RegWriteW;
  logic [ADDR_W-1:0] RdW;
  logic              PCSrcE;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              StallF;
  logic              StallD;
  logic              StallEM;
  logic              FlushD;
  logic              dmem_req;

  modport master (
    output RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD, ALUOpD,
           Rs1D, Rs2D, RdD, BrCondE, dmem_ready,
    input  ALUSrcE, ALUOpE, MemWriteM, ResultSrcW, RegWriteW, RdW, PCSrcE,
           ForwardAE, ForwardBE, StallF, StallD, StallEM, FlushD, dmem_req
  );

  modport slave (
    input  RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD, ALUOpD,
           Rs1D, Rs2D, RdD, BrCondE, dmem_ready,
    output ALUSrcE, ALUOpE, MemWriteM, ResultSrcW, RegWriteW, RdW, PCSrcE,
           ForwardAE, ForwardBE, StallF, StallD, StallEM, FlushD, dmem_req
  );
endinterface

// File: rtl/pipeline_control_unit.sv
// 5-stage pipeline control: E/M/W control registers, forwarding, load-use and
// branch hazards, and a data-memory wait tracker that freezes the pipeline.
module pipeline_control_unit #(
  parameter int ADDR_W = 5
) (
  input logic                    clk,
  input logic                    rst,
  pipeline_control_unit_if.slave bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic              r_reg_write_e;
  logic [1:0]        r_result_src_e;
  logic              r_mem_write_e;
  logic              r_jump_e;
  logic              r_branch_e;
  logic              r_alu_src_e;
  logic [1:0]        r_alu_op_e;
  logic [ADDR_W-1:0] r_rs1_e;
  logic [ADDR_W-1:0] r_rs2_e;
  logic [ADDR_W-1:0] r_rd_e;

  logic              r_reg_write_m;
  logic [1:0]        r_result_src_m;
  logic              r_mem_write_m;
  logic [ADDR_W-1:0] r_rd_m;

  logic              r_reg_write_w;
  logic [1:0]        r_result_src_w;
  logic [ADDR_W-1:0] r_rd_w;

  logic w_mem_acc;
  logic w_mem_stall;
  logic w_pcsrc;
  logic w_lw_stall;
  logic w_flush_e;

  logic [ADDR_W-1:0] w_rs_e [2];
  logic [1:0]        w_fwd  [2];

  assign w_mem_acc   = r_mem_write_m | (r_result_src_m == 2'b01);
  assign w_mem_stall = w_mem_acc & ~bus.dmem_ready;
  assign w_pcsrc     = (r_branch_e & bus.BrCondE) | r_jump_e;
  // A memory freeze outranks both the load-use bubble and the branch flush.
  assign w_lw_stall  = ~w_mem_stall & (r_result_src_e == 2'b01) & (r_rd_e != '0) &
                       ((r_rd_e == bus.Rs1D) | (r_rd_e == bus.Rs2D));
  assign w_flush_e   = ~w_mem_stall & (w_lw_stall | w_pcsrc);

  assign w_rs_e[0] = r_rs1_e;
  assign w_rs_e[1] = r_rs2_e;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign w_fwd[gi] =
        (r_reg_write_m && r_rd_m != '0 && r_rd_m == w_rs_e[gi]) ? 2'b10 :
        (r_reg_write_w && r_rd_w != '0 && r_rd_w == w_rs_e[gi]) ? 2'b01 : 2'b00;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg_write_e  <= 1'b0;
      r_result_src_e <= 2'b00;
      r_mem_write_e  <= 1'b0;
      r_jump_e       <= 1'b0;
      r_branch_e     <= 1'b0;
      r_alu_src_e    <= 1'b0;
      r_alu_op_e     <= 2'b00;
      r_rs1_e        <= '0;
      r_rs2_e        <= '0;
      r_rd_e         <= '0;
      r_reg_write_m  <= 1'b0;
      r_result_src_m <= 2'b00;
      r_mem_write_m  <= 1'b0;
      r_rd_m         <= '0;
      r_reg_write_w  <= 1'b0;
      r_result_src_w <= 2'b00;
      r_rd_w         <= '0;
    end else if (w_mem_stall) begin
      // E and M freeze; W takes a bubble so the stalled M op is not retired twice.
      r_reg_write_w  <= 1'b0;
      r_result_src_w <= 2'b00;
      r_rd_w         <= '0;
    end else begin
      r_reg_write_w  <= r_reg_write_m;
      r_result_src_w <= r_result_src_m;
      r_rd_w         <= r_rd_m;
      r_reg_write_m  <= r_reg_write_e;
      r_result_src_m <= r_result_src_e;
      r_mem_write_m  <= r_mem_write_e;
      r_rd_m         <= r_rd_e;
      if (w_flush_e) begin
        r_reg_write_e  <= 1'b0;
        r_result_src_e <= 2'b00;
        r_mem_write_e  <= 1'b0;
        r_jump_e       <= 1'b0;
        r_branch_e     <= 1'b0;
        r_alu_src_e    <= 1'b0;
        r_alu_op_e     <= 2'b00;
        r_rs1_e        <= '0;
        r_rs2_e        <= '0;
        r_rd_e         <= '0;
      end else begin
        r_reg_write_e  <= bus.RegWriteD;
        r_result_src_e <= bus.ResultSrcD;
        r_mem_write_e  <= bus.MemWriteD;
        r_jump_e       <= bus.JumpD;
        r_branch_e     <= bus.BranchD;
        r_alu_src_e    <= bus.ALUSrcD;
        r_alu_op_e     <= bus.ALUOpD;
        r_rs1_e        <= bus.Rs1D;
        r_rs2_e        <= bus.Rs2D;
        r_rd_e         <= bus.RdD;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Status-only tracker; the stall itself comes from w_mem_stall.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_mem_stall)    w_state_next = ST_WAIT;
      ST_WAIT: if (bus.dmem_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign bus.ALUSrcE    = r_alu_src_e;
  assign bus.ALUOpE     = r_alu_op_e;
  assign bus.MemWriteM  = r_mem_write_m;
  assign bus.ResultSrcW = r_result_src_w;
  assign bus.RegWriteW  = r_reg_write_w;
  assign bus.RdW        = r_rd_w;
  assign bus.PCSrcE     = w_pcsrc;
  assign bus.ForwardAE  = w_fwd[0];
  assign bus.ForwardBE  = w_fwd[1];
  assign bus.StallF     = w_mem_stall | w_lw_stall;
  assign bus.StallD     = w_mem_stall | w_lw_stall;
  assign bus.StallEM    = w_mem_stall;
  assign bus.FlushD     = w_pcsrc & ~w_mem_stall;
  assign bus.dmem_req   = w_mem_acc;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench for pipeline_control_unit: hazards, forwarding and memory wait.
module tb_pipeline_control_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  pipeline_control_unit_if #(.ADDR_W(5)) bus ();

  pipeline_control_unit #(.ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_d(input logic rw, input logic [1:0] rs, input logic mw,
                       input logic j, input logic b, input logic as,
                       input logic [1:0] aop, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd);
    bus.RegWriteD  = rw;
    bus.ResultSrcD = rs;
    bus.MemWriteD  = mw;
    bus.JumpD      = j;
    bus.BranchD    = b;
    bus.ALUSrcD    = as;
    bus.ALUOpD     = aop;
    bus.Rs1D       = rs1;
    bus.Rs2D       = rs2;
    bus.RdD        = rd;
  endtask

  task automatic set_nop();
    set_d(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic drain();
    set_nop();
    bus.BrCondE    = 1'b0;
    bus.dmem_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_nop();
    bus.BrCondE    = 1'b0;
    bus.dmem_ready = 1'b0;
    #3;
    n_checks++;
    if ({bus.ALUSrcE, bus.ALUOpE, bus.MemWriteM, bus.ResultSrcW, bus.RegWriteW, bus.RdW,
         bus.PCSrcE, bus.ForwardAE, bus.ForwardBE, bus.StallF, bus.StallD, bus.StallEM,
         bus.FlushD, bus.dmem_req} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    step();
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (bus.dmem_req !== 1'b0 || bus.StallF !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: dmem_req=%0b StallF=%0b required 0 0", bus.dmem_req, bus.StallF);
    end
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    drain();
    set_d(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd1, 5'd0, 5'd5); // lw x5
    step();
    set_d(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd5, 5'd2, 5'd6); // add x6,x5,x2
    #1;
    n_checks++;
    if ({bus.StallF, bus.StallD, bus.StallEM, bus.FlushD} !== 4'b1100) begin
      n_fail++;
      $display("FAIL lu_stall: got F/D/EM/Flush=%b required 1100",
               {bus.StallF, bus.StallD, bus.StallEM, bus.FlushD});
    end
    n_checks++;
    if (bus.ALUSrcE !== 1'b1) begin
      n_fail++;
      $display("FAIL lu_load_in_e: ALUSrcE=%0b required 1", bus.ALUSrcE);
    end
    step();
    n_checks++;
    if ({bus.ALUSrcE, bus.ALUOpE, bus.StallF, bus.dmem_req} !== 5'b00001) begin
      n_fail++;
      $display("FAIL lu_bubble: ALUSrcE/ALUOpE/StallF/dmem_req=%b required 00001",
               {bus.ALUSrcE, bus.ALUOpE, bus.StallF, bus.dmem_req});
    end
    step();
    n_checks++;
    if (bus.ForwardAE !== 2'b01 || bus.ForwardBE !== 2'b00) begin
      n_fail++;
      $display("FAIL lu_forward: FwdA=%b FwdB=%b required 01 00", bus.ForwardAE, bus.ForwardBE);
    end
    n_checks++;
    if ({bus.RegWriteW, bus.ResultSrcW, bus.RdW, bus.ALUOpE} !== {1'b1, 2'b01, 5'd5, 2'b10}) begin
      n_fail++;
      $display("FAIL lu_wb: RegWriteW=%0b ResultSrcW=%b RdW=%0d ALUOpE=%b required 1 01 5 10",
               bus.RegWriteW, bus.ResultSrcW, bus.RdW, bus.ALUOpE);
    end
    $display("test_load_use done");
  endtask

  task automatic test_forwarding();
    drain();
    set_d(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd1, 5'd2, 5'd3); // add x3 (to W)
    step();
    set_d(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd1, 5'd2, 5'd3); // add x3 (to M)
    step();
    set_d(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd3, 5'd3, 5'd7); // sub x7,x3,x3
    step();
    set_nop();
    #1;
    n_checks++;
    if (bus.ForwardAE !== 2'b10 || bus.ForwardBE !== 2'b10) begin
      n_fail++;
      $display("FAIL fwd_m_priority: FwdA=%b FwdB=%b required 10 10", bus.ForwardAE, bus.ForwardBE);
    end
    drain();
    set_d(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd1, 5'd2, 5'd3); // add x3 (to W)
    step();
    set_d(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd1, 5'd2, 5'd0); // add x0 (to M)
    step();
    set_d(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd3, 5'd0, 5'd7); // sub x7,x3,x0
    step();
    set_nop();
    #1;
    n_checks++;
    if (bus.ForwardAE !== 2'b01 || bus.ForwardBE !== 2'b00) begin
      n_fail++;
      $display("FAIL fwd_x0_in_m: FwdA=%b FwdB=%b required 01 00", bus.ForwardAE, bus.ForwardBE);
    end
    drain();
    set_d(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 5'd1, 5'd2, 5'd4); // no-write op, rd=4
    step();
    set_d(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd9, 5'd4, 5'd8); // uses x4 as rs2
    bus.dmem_ready = 1'b1;
    step();
    set_nop();
    #1;
    n_checks++;
    if (bus.ForwardAE !== 2'b00 || bus.ForwardBE !== 2'b00) begin
      n_fail++;
      $display("FAIL fwd_no_regwrite: FwdA=%b FwdB=%b required 00 00", bus.ForwardAE, bus.ForwardBE);
    end
    $display("test_forwarding done");
  endtask

  task automatic test_branch();
    drain();
    set_d(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 5'd1, 5'd2, 5'd0); // beq
    step();
    set_d(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd1, 5'd2, 5'd9);
    bus.BrCondE = 1'b1;
    #1;
    n_checks++;
    if ({bus.PCSrcE, bus.FlushD, bus.StallF, bus.ALUOpE} !== 5'b11001) begin
      n_fail++;
      $display("FAIL br_taken: PCSrc/Flush/StallF/ALUOpE=%b required 11001",
               {bus.PCSrcE, bus.FlushD, bus.StallF, bus.ALUOpE});
    end
    step();
    n_checks++;
    if (bus.ALUOpE !== 2'b00 || bus.PCSrcE !== 1'b0) begin
      n_fail++;
      $display("FAIL br_bubble: ALUOpE=%b PCSrcE=%0b required 00 0", bus.ALUOpE, bus.PCSrcE);
    end
    drain();
    set_d(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 5'd1, 5'd2, 5'd0); // beq
    step();
    set_d(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd1, 5'd2, 5'd9);
    bus.BrCondE = 1'b0;
    #1;
    n_checks++;
    if (bus.PCSrcE !== 1'b0 || bus.FlushD !== 1'b0) begin
      n_fail++;
      $display("FAIL br_not_taken: PCSrcE=%0b FlushD=%0b required 0 0", bus.PCSrcE, bus.FlushD);
    end
    step();
    n_checks++;
    if (bus.ALUOpE !== 2'b10) begin
      n_fail++;
      $display("FAIL br_no_bubble: ALUOpE=%b required 10", bus.ALUOpE);
    end
    $display("test_branch done");
  endtask

  task automatic test_mem_wait();
    drain();
    set_d(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd1, 5'd2, 5'd9);  // add x9
    step();
    set_d(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 5'd1, 5'd2, 5'd0);  // sw
    step();
    set_d(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd1, 5'd2, 5'd10); // add x10
    step();
    set_d(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 5'd1, 5'd2, 5'd11); // add x11
    bus.dmem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if ({bus.dmem_req, bus.StallF, bus.StallD, bus.StallEM, bus.MemWriteM, bus.ALUOpE} !== 7'b1111110) begin
        n_fail++;
        $display("FAIL mw_stall_c%0d: req/F/D/EM/MemWriteM/ALUOpE=%b required 1111110", k,
                 {bus.dmem_req, bus.StallF, bus.StallD, bus.StallEM, bus.MemWriteM, bus.ALUOpE});
      end
      if (k > 0) begin
        n_checks++;
        if (bus.RegWriteW !== 1'b0 || bus.RdW !== 5'd0 || dut.r_state !== 1'b1) begin
          n_fail++;
          $display("FAIL mw_wait_c%0d: RegWriteW=%0b RdW=%0d state=%0b required 0 0 1", k,
                   bus.RegWriteW, bus.RdW, dut.r_state);
        end
      end
      if (k < 2) step();
    end
    bus.dmem_ready = 1'b1;
    #1;
    n_checks++;
    if ({bus.dmem_req, bus.StallF, bus.StallEM} !== 3'b100) begin
      n_fail++;
      $display("FAIL mw_release: req/StallF/StallEM=%b required 100",
               {bus.dmem_req, bus.StallF, bus.StallEM});
    end
    step();
    n_checks++;
    if ({bus.MemWriteM, bus.dmem_req, bus.RegWriteW, bus.RdW, bus.ALUOpE} !== {3'b000, 5'd0, 2'b11} ||
        dut.r_state !== 1'b0) begin
      n_fail++;
      $display("FAIL mw_exit: MemWriteM=%0b req=%0b RegWriteW=%0b RdW=%0d ALUOpE=%b state=%0b required 0 0 0 0 11 0",
               bus.MemWriteM, bus.dmem_req, bus.RegWriteW, bus.RdW, bus.ALUOpE, dut.r_state);
    end
    $display("test_mem_wait done");
  endtask

  task automatic test_stall_jump();
    drain();
    set_d(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd1, 5'd0, 5'd8); // lw x8
    step();
    set_d(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd1); // jal x1
    step();
    set_d(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd1, 5'd2, 5'd12);
    bus.dmem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++;
      if ({bus.PCSrcE, bus.FlushD, bus.StallF, bus.StallEM} !== 4'b1011) begin
        n_fail++;
        $display("FAIL sj_wait_c%0d: PCSrc/Flush/StallF/StallEM=%b required 1011", k,
                 {bus.PCSrcE, bus.FlushD, bus.StallF, bus.StallEM});
      end
      step();
    end
    bus.dmem_ready = 1'b1;
    #1;
    n_checks++;
    if ({bus.PCSrcE, bus.FlushD, bus.StallF, bus.StallEM} !== 4'b1100) begin
      n_fail++;
      $display("FAIL sj_release: PCSrc/Flush/StallF/StallEM=%b required 1100",
               {bus.PCSrcE, bus.FlushD, bus.StallF, bus.StallEM});
    end
    step();
    n_checks++;
    if ({bus.PCSrcE, bus.RegWriteW, bus.ResultSrcW, bus.RdW} !== {1'b0, 1'b1, 2'b01, 5'd8}) begin
      n_fail++;
      $display("FAIL sj_after: PCSrcE=%0b RegWriteW=%0b ResultSrcW=%b RdW=%0d required 0 1 01 8",
               bus.PCSrcE, bus.RegWriteW, bus.ResultSrcW, bus.RdW);
    end
    $display("test_stall_jump done");
  endtask

  task automatic test_reset_mid_wait();
    drain();
    set_d(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd1, 5'd0, 5'd13); // lw x13
    step();
    set_nop();
    step();
    bus.dmem_ready = 1'b0;
    step();
    #1;
    n_checks++;
    if (bus.dmem_req !== 1'b1 || dut.r_state !== 1'b1) begin
      n_fail++;
      $display("FAIL rmw_pre: dmem_req=%0b state=%0b required 1 1", bus.dmem_req, dut.r_state);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.dmem_req, bus.StallF, bus.StallEM, bus.RegWriteW, bus.RdW} !== 9'd0 ||
        dut.r_state !== 1'b0) begin
      n_fail++;
      $display("FAIL rmw_async: req=%0b StallF=%0b StallEM=%0b RegWriteW=%0b RdW=%0d state=%0b required all 0",
               bus.dmem_req, bus.StallF, bus.StallEM, bus.RegWriteW, bus.RdW, dut.r_state);
    end
    step();
    rst = 1'b0;
    bus.dmem_ready = 1'b1;
    step();
    step();
    n_checks++;
    if (bus.RegWriteW !== 1'b0 || bus.RdW !== 5'd0 || bus.dmem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rmw_no_wb: RegWriteW=%0b RdW=%0d req=%0b required 0 0 0",
               bus.RegWriteW, bus.RdW, bus.dmem_req);
    end
    $display("test_reset_mid_wait done");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch();
    test_mem_wait();
    test_stall_jump();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
